hazard_unit: RTL and testbench
==============================

# hazard_unit

Parametrised hazard-detection and operand-forwarding controller for the in-order pipelined core. It tracks the destination tags of every in-flight instruction between decode and writeback, drives the forwarded rs1/rs2 operand values into the decode buffer, and raises decode stall, bubble insertion and front-end flush. It generalises the fixed three-source forwarding/load-stall logic to any forwarding depth, any load latency and an optional hardwired zero register.

## Interface
- DBITS, 32, data width
- REG_INDEX_BIT_WIDTH, 4, register-number width
- FWD_STAGES, 3, in-flight stages after decode that can forward (1 = EX … FWD_STAGES = WB)
- LOAD_LAT, 1, extra cycles after EX before load data is forwardable (1..FWD_STAGES-1)
- R0_HARDWIRED, 0, 1 = register 0 reads as zero and is never a hazard

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high
- dec_valid  in  1  decode slot holds a real instruction
- dec_rs1, dec_rs2  in  REG_INDEX_BIT_WIDTH  source register numbers (after rs muxing)
- dec_use1, dec_use2  in  1  source actually read
- dec_rd  in  REG_INDEX_BIT_WIDTH  destination register
- dec_wr_reg, dec_is_load  in  1  writes a register / is a load
- rf_data1, rf_data2  in  DBITS  register-file read data
- stage_data  in  FWD_STAGES*DBITS  result of stage k at slice [k*DBITS-1:(k-1)*DBITS]
- redirect  in  1  taken branch/JAL resolved in EX
- fwd_data1, fwd_data2  out  DBITS  forwarded operands
- fwd_sel1, fwd_sel2  out  $clog2(FWD_STAGES+1)  0 = register file, k = stage k
- stall_dec  out  1  hold PC and decode buffer
- flush_fetch, flush_dec  out  1  squash instruction buffer / decode slot
- perf_stalls, perf_flushes  out  32  event counters

## Operation
- Tag pipeline: FWD_STAGES entries {valid, rd, is_load}; entry k describes the instruction in stage k.
- Each cycle, entry k+1 ← entry k; entry FWD_STAGES retires. Entry 1 ← {dec_valid & dec_wr_reg & ~stall_dec & ~redirect, dec_rd, dec_is_load}.
- Match k for source s: use_s & entry_k.valid & entry_k.rd == rs_s & ~(R0_HARDWIRED & rs_s == 0).
- Select: smallest matching k (youngest wins); none → 0. fwd_data = stage_data slice k, or rf_data. R0_HARDWIRED with rs = 0 → fwd_data = 0.
- Load-use: winning match with is_load and k ≤ LOAD_LAT → stall_dec = dec_valid. Older matches never override a stalled youngest match.
- stall_dec: PC and decode buffer hold; bubble (invalid tag) enters stage 1; older tags advance.
- redirect: flush_fetch = flush_dec = 1; decode-slot tag replaced by bubble; stall_dec forced 0 (redirect wins).
- No state machine beyond the tag shift register; all outputs combinational from tags and decode inputs.

## Timing
- Reset: all tags invalid; counters 0; with dec inputs idle, all outputs 0, fwd_data = rf_data.
- Tag update on posedge clk; reset mid-operation clears tags immediately (async).
- Forwarding/stall latency 0 cycles (same-cycle combinational). Load in EX with LOAD_LAT = 1 → exactly 1 stall cycle; LOAD_LAT = n → up to n cycles.
- Stall and redirect same cycle → redirect only, stall_dec = 0.
- dec_valid = 0 → stall_dec = 0, no tag entered.

## Configuration
- HAZARD_PERF_CNT_EN defined: perf_stalls increments each cycle stall_dec = 1; perf_flushes increments each cycle redirect = 1; both wrap at 2^32, cleared by reset.
- Undefined: no counter flops; perf_stalls and perf_flushes tied to 0.

## Structure
- Package hazard_pkg: tag struct {valid, rd, is_load}, FWD_SEL_RF = 0 constant, select-width function.
- One sub-module: operand_fwd_mux (priority match + data select for one source), instantiated twice.

## Test plan
- ALU chain: add r3 decoded, next cycle decode reads r3 → fwd_sel1 = 1, fwd_data1 = stage_data slice 1 (0x0000_0005), stall_dec = 0.
- Load-use, LOAD_LAT = 1: lw r4 decoded, next decode reads r4 → stall_dec = 1 one cycle, then fwd_sel = 2, value 0xDEAD_BEEF.
- Youngest wins: r2 written by stages 1 and 3 (0x11, 0x33) → fwd_data2 = 0x11.
- Redirect with pending load-use stall → flush_fetch = flush_dec = 1, stall_dec = 0, stage-1 tag invalid next cycle.
- R0_HARDWIRED = 1, stage 1 writes r0, decode reads r0 → fwd_sel = 0, fwd_data = 0.
- HAZARD_PERF_CNT_EN: 3 stalls + 2 redirects → perf_stalls = 3, perf_flushes = 2; assert reset mid-run → both 0, all tags invalid.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared tag type, select encoding and width helper for hazard_unit
package hazard_pkg;

  localparam int TAG_RD_BITS = 8;
  localparam int FWD_SEL_RF  = 0;

  typedef struct packed {
    logic                   valid;
    logic [TAG_RD_BITS-1:0] rd;
    logic                   isLoad;
  } tag_t;

  function automatic int selWidth(input int stages);
    return (stages < 1) ? 1 : $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/hazard_unit_operand_fwd_mux.sv
// rtl/hazard_unit_operand_fwd_mux.sv - youngest-match priority select and operand mux for one source
module operand_fwd_mux
  import hazard_pkg::*;
#(
  parameter int DBITS               = 32,
  parameter int REG_INDEX_BIT_WIDTH = 4,
  parameter int FWD_STAGES          = 3,
  parameter int LOAD_LAT            = 1,
  parameter int R0_HARDWIRED        = 0,
  parameter int SEL_W               = selWidth(FWD_STAGES)
) (
  input  logic                           srcUse,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] rs,
  input  tag_t [FWD_STAGES-1:0]          tags,
  input  logic [DBITS-1:0]               rfData,
  input  logic [FWD_STAGES*DBITS-1:0]    stageData,
  output logic [DBITS-1:0]               fwdData,
  output logic [SEL_W-1:0]               fwdSel,
  output logic                           loadUse
);

  logic                   rsIsZero;
  logic [TAG_RD_BITS-1:0] rsExt;
  logic                   hit;
  logic                   winLoad;

  assign rsExt    = TAG_RD_BITS'(rs);
  assign rsIsZero = (R0_HARDWIRED != 0) && (rs == '0);

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    hit     = 1'b0;
    winLoad = 1'b0;
    fwdSel  = SEL_W'(FWD_SEL_RF);
    for (int k = FWD_STAGES; k >= 1; k--) begin
      if (srcUse && tags[k-1].valid && (tags[k-1].rd == rsExt) && !rsIsZero) begin
        hit     = 1'b1;
        winLoad = tags[k-1].isLoad;
        fwdSel  = SEL_W'(k);
      end
    end
  end

  always_comb begin
    fwdData = rfData;
    if (rsIsZero) begin
      fwdData = '0;
    end else if (hit) begin
      for (int k = 1; k <= FWD_STAGES; k++) begin
        if (fwdSel == SEL_W'(k)) fwdData = stageData[(k-1)*DBITS +: DBITS];
      end
    end
  end

  // A load result is not ready until it has passed LOAD_LAT stages.
  assign loadUse = hit && winLoad && (int'(fwdSel) <= LOAD_LAT);

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - tag pipeline, forwarding, load-use stall and redirect flush (HAZARD_PERF_CNT_EN adds event counters)
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int DBITS               = 32,
  parameter int REG_INDEX_BIT_WIDTH = 4,
  parameter int FWD_STAGES          = 3,
  parameter int LOAD_LAT            = 1,
  parameter int R0_HARDWIRED        = 0,
  localparam int SEL_W              = selWidth(FWD_STAGES)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           dec_valid,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] dec_rs1,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] dec_rs2,
  input  logic                           dec_use1,
  input  logic                           dec_use2,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] dec_rd,
  input  logic                           dec_wr_reg,
  input  logic                           dec_is_load,
  input  logic [DBITS-1:0]               rf_data1,
  input  logic [DBITS-1:0]               rf_data2,
  input  logic [FWD_STAGES*DBITS-1:0]    stage_data,
  input  logic                           redirect,
  output logic [DBITS-1:0]               fwd_data1,
  output logic [DBITS-1:0]               fwd_data2,
  output logic [SEL_W-1:0]               fwd_sel1,
  output logic [SEL_W-1:0]               fwd_sel2,
  output logic                           stall_dec,
  output logic                           flush_fetch,
  output logic                           flush_dec,
  output logic [31:0]                    perf_stalls,
  output logic [31:0]                    perf_flushes
);

  tag_t [FWD_STAGES-1:0] tags;
  tag_t                  newTag;
  logic                  loadUse1;
  logic                  loadUse2;

  operand_fwd_mux #(
    .DBITS(DBITS), .REG_INDEX_BIT_WIDTH(REG_INDEX_BIT_WIDTH), .FWD_STAGES(FWD_STAGES),
    .LOAD_LAT(LOAD_LAT), .R0_HARDWIRED(R0_HARDWIRED), .SEL_W(SEL_W)
  ) muxSrc1 (
    .srcUse(dec_use1), .rs(dec_rs1), .tags(tags), .rfData(rf_data1),
    .stageData(stage_data), .fwdData(fwd_data1), .fwdSel(fwd_sel1), .loadUse(loadUse1)
  );

  operand_fwd_mux #(
    .DBITS(DBITS), .REG_INDEX_BIT_WIDTH(REG_INDEX_BIT_WIDTH), .FWD_STAGES(FWD_STAGES),
    .LOAD_LAT(LOAD_LAT), .R0_HARDWIRED(R0_HARDWIRED), .SEL_W(SEL_W)
  ) muxSrc2 (
    .srcUse(dec_use2), .rs(dec_rs2), .tags(tags), .rfData(rf_data2),
    .stageData(stage_data), .fwdData(fwd_data2), .fwdSel(fwd_sel2), .loadUse(loadUse2)
  );

  // Redirect squashes the decode slot, so a pending load-use stall is moot.
  assign stall_dec   = dec_valid & (loadUse1 | loadUse2) & ~redirect;
  assign flush_fetch = redirect;
  assign flush_dec   = redirect;

  always_comb begin
    newTag        = '0;
    newTag.valid  = dec_valid & dec_wr_reg & ~stall_dec & ~redirect;
    newTag.rd     = TAG_RD_BITS'(dec_rd);
    newTag.isLoad = dec_is_load;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tags <= '0;
    end else begin
      tags[0] <= newTag;
      for (int k = 1; k < FWD_STAGES; k++) begin
        tags[k] <= tags[k-1];
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stallCnt;
  logic [31:0] flushCnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (stall_dec) stallCnt <= stallCnt + 32'd1;
      if (redirect)  flushCnt <= flushCnt + 32'd1;
    end
  end

  assign perf_stalls  = stallCnt;
  assign perf_flushes = flushCnt;
`else
  assign perf_stalls  = '0;
  assign perf_flushes = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed self-checking bench for hazard_unit
module tb_hazard_unit;

  localparam int DBITS = 32;
  localparam int RW    = 4;
  localparam int FS    = 3;
  localparam int SW    = $clog2(FS + 1);
`ifdef HAZARD_PERF_CNT_EN
  localparam logic [31:0] EXP_STALLS  = 32'd3;
  localparam logic [31:0] EXP_FLUSHES = 32'd2;
`else
  localparam logic [31:0] EXP_STALLS  = 32'd0;
  localparam logic [31:0] EXP_FLUSHES = 32'd0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             dec_valid, dec_use1, dec_use2, dec_wr_reg, dec_is_load, redirect;
  logic [RW-1:0]    dec_rs1, dec_rs2, dec_rd;
  logic [DBITS-1:0] rf_data1, rf_data2;
  logic [FS*DBITS-1:0] stage_data;

  logic [DBITS-1:0] fwd_data1, fwd_data2, r0Data1, r0Data2;
  logic [SW-1:0]    fwd_sel1, fwd_sel2, r0Sel1, r0Sel2;
  logic             stall_dec, flush_fetch, flush_dec, r0Stall, r0FlushF, r0FlushD;
  logic [31:0]      perf_stalls, perf_flushes, r0PerfS, r0PerfF;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_unit #(.DBITS(DBITS), .REG_INDEX_BIT_WIDTH(RW), .FWD_STAGES(FS), .LOAD_LAT(1), .R0_HARDWIRED(0)) dut (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_use1(dec_use1), .dec_use2(dec_use2), .dec_rd(dec_rd), .dec_wr_reg(dec_wr_reg),
    .dec_is_load(dec_is_load), .rf_data1(rf_data1), .rf_data2(rf_data2), .stage_data(stage_data),
    .redirect(redirect), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2), .fwd_sel1(fwd_sel1),
    .fwd_sel2(fwd_sel2), .stall_dec(stall_dec), .flush_fetch(flush_fetch), .flush_dec(flush_dec),
    .perf_stalls(perf_stalls), .perf_flushes(perf_flushes)
  );

  hazard_unit #(.DBITS(DBITS), .REG_INDEX_BIT_WIDTH(RW), .FWD_STAGES(FS), .LOAD_LAT(1), .R0_HARDWIRED(1)) dutR0 (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_use1(dec_use1), .dec_use2(dec_use2), .dec_rd(dec_rd), .dec_wr_reg(dec_wr_reg),
    .dec_is_load(dec_is_load), .rf_data1(rf_data1), .rf_data2(rf_data2), .stage_data(stage_data),
    .redirect(redirect), .fwd_data1(r0Data1), .fwd_data2(r0Data2), .fwd_sel1(r0Sel1),
    .fwd_sel2(r0Sel2), .stall_dec(r0Stall), .flush_fetch(r0FlushF), .flush_dec(r0FlushD),
    .perf_stalls(r0PerfS), .perf_flushes(r0PerfF)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic setDec(input logic v, input logic [RW-1:0] r1, input logic u1,
                        input logic [RW-1:0] r2, input logic u2,
                        input logic [RW-1:0] rd, input logic wr, input logic ld);
    dec_valid = v; dec_rs1 = r1; dec_use1 = u1; dec_rs2 = r2; dec_use2 = u2;
    dec_rd = rd; dec_wr_reg = wr; dec_is_load = ld;
  endtask

  task automatic drain(input int n);
    repeat (n) begin
      @(negedge clk);
      setDec(0, 0, 0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic loadUsePair(input string tag);
    @(negedge clk); setDec(1, 0, 0, 0, 0, 4'd4, 1, 1);
    @(negedge clk); setDec(1, 4'd4, 1, 0, 0, 4'd6, 1, 0); #2;
    checkVal({tag, "_stall"}, 32'(stall_dec), 32'd1);
    @(negedge clk); #2;
    checkVal({tag, "_release"}, 32'(stall_dec), 32'd0);
    drain(3);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; redirect = 1'b0;
    setDec(0, 0, 0, 0, 0, 0, 0, 0);
    rf_data1 = 32'h0000_00A1; rf_data2 = 32'h0000_00A2;
    stage_data = {32'h0000_0033, 32'hDEAD_BEEF, 32'h0000_0005};
    #2;
    checkVal("rst_sel1",  32'(fwd_sel1), 32'd0);
    checkVal("rst_data1", fwd_data1, 32'h0000_00A1);
    checkVal("rst_data2", fwd_data2, 32'h0000_00A2);
    checkVal("rst_stall", 32'(stall_dec), 32'd0);
    checkVal("rst_flush", 32'({flush_fetch, flush_dec}), 32'd0);
    checkVal("rst_perf",  perf_stalls | perf_flushes, 32'd0);
    @(negedge clk); reset = 1'b0;

    // ALU chain: add r3, then read r3
    @(negedge clk); setDec(1, 0, 0, 0, 0, 4'd3, 1, 0);
    @(negedge clk); setDec(1, 4'd3, 1, 4'd7, 1, 4'd5, 0, 0); #2;
    checkVal("alu_sel1",  32'(fwd_sel1), 32'd1);
    checkVal("alu_data1", fwd_data1, 32'h0000_0005);
    checkVal("alu_stall", 32'(stall_dec), 32'd0);
    checkVal("alu_sel2",  32'(fwd_sel2), 32'd0);
    checkVal("alu_data2", fwd_data2, 32'h0000_00A2);
    drain(3);

    // Load-use: one stall, then forward from stage 2
    @(negedge clk); setDec(1, 0, 0, 0, 0, 4'd4, 1, 1);
    @(negedge clk); setDec(1, 4'd4, 1, 0, 0, 4'd6, 1, 0); #2;
    checkVal("lu_stall", 32'(stall_dec), 32'd1);
    @(negedge clk); #2;
    checkVal("lu_stall2", 32'(stall_dec), 32'd0);
    checkVal("lu_sel1",   32'(fwd_sel1), 32'd2);
    checkVal("lu_data1",  fwd_data1, 32'hDEAD_BEEF);
    drain(3);

    // Invalid decode slot never stalls
    @(negedge clk); setDec(1, 0, 0, 0, 0, 4'd4, 1, 1);
    @(negedge clk); setDec(0, 4'd4, 1, 0, 0, 4'd6, 1, 0); #2;
    checkVal("nv_stall", 32'(stall_dec), 32'd0);
    drain(3);

    // Youngest wins: r2 in stages 1 and 3, r9 in stage 2
    stage_data = {32'h0000_0033, 32'hDEAD_BEEF, 32'h0000_0011};
    @(negedge clk); setDec(1, 0, 0, 0, 0, 4'd2, 1, 0);
    @(negedge clk); setDec(1, 0, 0, 0, 0, 4'd9, 1, 0);
    @(negedge clk); setDec(1, 0, 0, 0, 0, 4'd2, 1, 0);
    @(negedge clk); setDec(1, 4'd9, 1, 4'd2, 1, 0, 0, 0); #2;
    checkVal("yw_sel2",  32'(fwd_sel2), 32'd1);
    checkVal("yw_data2", fwd_data2, 32'h0000_0011);
    checkVal("yw_sel1",  32'(fwd_sel1), 32'd2);
    checkVal("yw_data1", fwd_data1, 32'hDEAD_BEEF);
    @(negedge clk); setDec(1, 4'd9, 1, 0, 0, 0, 0, 0); #2;
    checkVal("wb_sel1",  32'(fwd_sel1), 32'd3);
    checkVal("wb_data1", fwd_data1, 32'h0000_0033);
    drain(3);

    // Redirect overrides a pending load-use stall and squashes the slot
    @(negedge clk); setDec(1, 0, 0, 0, 0, 4'd4, 1, 1);
    @(negedge clk); setDec(1, 4'd4, 1, 0, 0, 4'd8, 1, 0); redirect = 1'b1; #2;
    checkVal("rd_flushf", 32'(flush_fetch), 32'd1);
    checkVal("rd_flushd", 32'(flush_dec), 32'd1);
    checkVal("rd_stall",  32'(stall_dec), 32'd0);
    @(negedge clk); redirect = 1'b0; setDec(1, 4'd8, 1, 4'd4, 1, 0, 0, 0); #2;
    checkVal("rd_sel1",   32'(fwd_sel1), 32'd0);
    checkVal("rd_data1",  fwd_data1, 32'h0000_00A1);
    checkVal("rd_sel2",   32'(fwd_sel2), 32'd2);
    checkVal("rd_stall2", 32'(stall_dec), 32'd0);
    @(negedge clk); setDec(0, 0, 0, 0, 0, 0, 0, 0); redirect = 1'b1; #2;
    checkVal("rd2_flush", 32'(flush_fetch), 32'd1);
    @(negedge clk); redirect = 1'b0;
    drain(3);

    // Hardwired r0 vs ordinary r0
    @(negedge clk); setDec(1, 0, 0, 0, 0, 4'd0, 1, 0);
    @(negedge clk); setDec(1, 4'd0, 1, 0, 0, 0, 0, 0); #2;
    checkVal("r0_sel1",    32'(r0Sel1), 32'd0);
    checkVal("r0_data1",   r0Data1, 32'd0);
    checkVal("nor0_sel1",  32'(fwd_sel1), 32'd1);
    checkVal("nor0_data1", fwd_data1, 32'h0000_0011);
    drain(3);

    loadUsePair("lu2");
    loadUsePair("lu3");
    checkVal("perf_stalls",  perf_stalls, EXP_STALLS);
    checkVal("perf_flushes", perf_flushes, EXP_FLUSHES);

    // Asynchronous reset mid-run clears tags and counters at once
    @(negedge clk); setDec(1, 0, 0, 0, 0, 4'd4, 1, 1);
    @(negedge clk); setDec(1, 4'd4, 1, 0, 0, 0, 0, 0); #2;
    checkVal("mr_pre_stall", 32'(stall_dec), 32'd1);
    #1 reset = 1'b1; #1;
    checkVal("mr_stall", 32'(stall_dec), 32'd0);
    checkVal("mr_sel1",  32'(fwd_sel1), 32'd0);
    checkVal("mr_data1", fwd_data1, 32'h0000_00A1);
    checkVal("mr_perfs", perf_stalls, 32'd0);
    checkVal("mr_perff", perf_flushes, 32'd0);
    @(negedge clk); reset = 1'b0; #2;
    checkVal("mr_after_sel1", 32'(fwd_sel1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
